// File: rtl/axi_arb_pkg.sv
`default_nettype none
//==============================================================================
// Package  : axi_arb_pkg
// Brief    : Shared widths, FSM encodings and AXI constants for the 2x1 arbiter.
// Revision : 1.0
//==============================================================================
package axi_arb_pkg;

   localparam int unsigned c_ADDR_W = 32;
   localparam int unsigned c_DATA_W = 64;
   localparam int unsigned c_ID_W   = 4;
   localparam int unsigned c_STRB_W = c_DATA_W / 8;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } burst_e;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ACT  = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   // Kind of the most recent grant; the opposite kind wins a read/write collision.
   typedef enum logic {
      KIND_READ  = 1'b0,
      KIND_WRITE = 1'b1
   } rw_kind_e;

endpackage
`default_nettype wire

// File: rtl/axi_arbiter_2x1_rr_arb2.sv
`default_nettype none
//==============================================================================
// Module   : rr_arb2
// Brief    : Two-request round-robin picker; grant is an index, valid = any req.
// Revision : 1.0
//==============================================================================
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant,
   output logic       valid
);

   assign valid = |req;
   assign grant = (&req) ? ~last : req[1];

endmodule
`default_nettype wire

// File: rtl/axi_arbiter_2x1.sv
`default_nettype none
//==============================================================================
// Module   : axi_arbiter_2x1
// Brief    : 2-master to 1-slave AXI4 arbiter, one burst outstanding at a time.
// Revision : 1.0
//==============================================================================
module axi_arbiter_2x1
   import axi_arb_pkg::*;
#(
   parameter int ADDR_W = c_ADDR_W,
   parameter int DATA_W = c_DATA_W,
   parameter int ID_W   = c_ID_W
) (
   input  logic                aclk,
   input  logic                aresetn,
   // master 0 (instruction fetch)
   input  logic [ADDR_W-1:0]   s0_araddr,
   input  logic [ID_W-1:0]     s0_arid,
   input  logic [7:0]          s0_arlen,
   input  logic [2:0]          s0_arsize,
   input  logic [1:0]          s0_arburst,
   input  logic                s0_arvalid,
   output logic                s0_arready,
   output logic [ID_W-1:0]     s0_rid,
   output logic [DATA_W-1:0]   s0_rdata,
   output logic [1:0]          s0_rresp,
   output logic                s0_rlast,
   output logic                s0_rvalid,
   input  logic                s0_rready,
   input  logic [ADDR_W-1:0]   s0_awaddr,
   input  logic [ID_W-1:0]     s0_awid,
   input  logic [7:0]          s0_awlen,
   input  logic [2:0]          s0_awsize,
   input  logic [1:0]          s0_awburst,
   input  logic                s0_awvalid,
   output logic                s0_awready,
   input  logic [DATA_W-1:0]   s0_wdata,
   input  logic [DATA_W/8-1:0] s0_wstrb,
   input  logic                s0_wlast,
   input  logic                s0_wvalid,
   output logic                s0_wready,
   output logic [ID_W-1:0]     s0_bid,
   output logic [1:0]          s0_bresp,
   output logic                s0_bvalid,
   input  logic                s0_bready,
   // master 1 (load/store)
   input  logic [ADDR_W-1:0]   s1_araddr,
   input  logic [ID_W-1:0]     s1_arid,
   input  logic [7:0]          s1_arlen,
   input  logic [2:0]          s1_arsize,
   input  logic [1:0]          s1_arburst,
   input  logic                s1_arvalid,
   output logic                s1_arready,
   output logic [ID_W-1:0]     s1_rid,
   output logic [DATA_W-1:0]   s1_rdata,
   output logic [1:0]          s1_rresp,
   output logic                s1_rlast,
   output logic                s1_rvalid,
   input  logic                s1_rready,
   input  logic [ADDR_W-1:0]   s1_awaddr,
   input  logic [ID_W-1:0]     s1_awid,
   input  logic [7:0]          s1_awlen,
   input  logic [2:0]          s1_awsize,
   input  logic [1:0]          s1_awburst,
   input  logic                s1_awvalid,
   output logic                s1_awready,
   input  logic [DATA_W-1:0]   s1_wdata,
   input  logic [DATA_W/8-1:0] s1_wstrb,
   input  logic                s1_wlast,
   input  logic                s1_wvalid,
   output logic                s1_wready,
   output logic [ID_W-1:0]     s1_bid,
   output logic [1:0]          s1_bresp,
   output logic                s1_bvalid,
   input  logic                s1_bready,
   // slave side
   output logic [ADDR_W-1:0]   m_araddr,
   output logic [ID_W-1:0]     m_arid,
   output logic [7:0]          m_arlen,
   output logic [2:0]          m_arsize,
   output logic [1:0]          m_arburst,
   output logic                m_arvalid,
   input  logic                m_arready,
   input  logic [ID_W-1:0]     m_rid,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic [1:0]          m_rresp,
   input  logic                m_rlast,
   input  logic                m_rvalid,
   output logic                m_rready,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic [ID_W-1:0]     m_awid,
   output logic [7:0]          m_awlen,
   output logic [2:0]          m_awsize,
   output logic [1:0]          m_awburst,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                m_wlast,
   output logic                m_wvalid,
   input  logic                m_wready,
   input  logic [ID_W-1:0]     m_bid,
   input  logic [1:0]          m_bresp,
   input  logic                m_bvalid,
   output logic                m_bready
);

   rd_state_e r_rd_state, w_rd_state_nxt;
   wr_state_e r_wr_state, w_wr_state_nxt;
   rw_kind_e  r_rw_last;
   logic      r_rg, r_wg, r_rr_rd, r_rr_wr, r_aw_done, r_w_done;

   logic w_rd_pick, w_rd_req, w_wr_pick, w_wr_req;
   logic w_both_idle, w_rd_start, w_wr_start;
   logic w_sel_arvalid, w_sel_rready, w_sel_awvalid, w_sel_wvalid, w_sel_wlast, w_sel_bready;
   logic w_ar_hs, w_r_end, w_aw_hs, w_w_last_hs, w_b_hs;

   rr_arb2 u_rd_pick (
      .req   ({s1_arvalid, s0_arvalid}),
      .last  (r_rr_rd),
      .grant (w_rd_pick),
      .valid (w_rd_req)
   );

   rr_arb2 u_wr_pick (
      .req   ({s1_awvalid, s0_awvalid}),
      .last  (r_rr_wr),
      .grant (w_wr_pick),
      .valid (w_wr_req)
   );

   // Only one transaction may be in flight at the slave, so both FSMs must be idle.
   assign w_both_idle = (r_rd_state == R_IDLE) && (r_wr_state == W_IDLE);
   assign w_rd_start  = w_both_idle && w_rd_req && (!w_wr_req || (r_rw_last == KIND_WRITE));
   assign w_wr_start  = w_both_idle && w_wr_req && (!w_rd_req || (r_rw_last == KIND_READ));

   assign w_sel_arvalid = r_rg ? s1_arvalid : s0_arvalid;
   assign w_sel_rready  = r_rg ? s1_rready  : s0_rready;
   assign w_sel_awvalid = r_wg ? s1_awvalid : s0_awvalid;
   assign w_sel_wvalid  = r_wg ? s1_wvalid  : s0_wvalid;
   assign w_sel_wlast   = r_wg ? s1_wlast   : s0_wlast;
   assign w_sel_bready  = r_wg ? s1_bready  : s0_bready;

   assign w_ar_hs     = (r_rd_state == R_ADDR) && w_sel_arvalid && m_arready;
   assign w_r_end     = (r_rd_state == R_DATA) && m_rvalid && w_sel_rready && m_rlast;
   assign w_aw_hs     = (r_wr_state == W_ACT) && !r_aw_done && w_sel_awvalid && m_awready;
   assign w_w_last_hs = (r_wr_state == W_ACT) && !r_w_done && w_sel_wvalid && m_wready && w_sel_wlast;
   assign w_b_hs      = (r_wr_state == W_RESP) && m_bvalid && w_sel_bready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rd_state <= R_IDLE;
         r_wr_state <= W_IDLE;
         r_rw_last  <= KIND_WRITE;
         r_rg       <= 1'b0;
         r_wg       <= 1'b0;
         r_rr_rd    <= 1'b1;
         r_rr_wr    <= 1'b1;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
      end else begin
         r_rd_state <= w_rd_state_nxt;
         r_wr_state <= w_wr_state_nxt;
         if (w_rd_start) begin
            r_rg      <= w_rd_pick;
            r_rw_last <= KIND_READ;
         end
         if (w_wr_start) begin
            r_wg      <= w_wr_pick;
            r_rw_last <= KIND_WRITE;
         end
         if (w_r_end) r_rr_rd <= r_rg;
         if (w_b_hs) begin
            r_rr_wr   <= r_wg;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end else begin
            if (w_aw_hs)     r_aw_done <= 1'b1;
            if (w_w_last_hs) r_w_done  <= 1'b1;
         end
      end
   end

   always_comb begin
      w_rd_state_nxt = r_rd_state;
      case (r_rd_state)
         R_IDLE:  if (w_rd_start) w_rd_state_nxt = R_ADDR;
         R_ADDR:  if (w_ar_hs)    w_rd_state_nxt = R_DATA;
         R_DATA:  if (w_r_end)    w_rd_state_nxt = R_IDLE;
         default: w_rd_state_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      w_wr_state_nxt = r_wr_state;
      case (r_wr_state)
         W_IDLE:  if (w_wr_start) w_wr_state_nxt = W_ACT;
         W_ACT:   if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_last_hs)) w_wr_state_nxt = W_RESP;
         W_RESP:  if (w_b_hs)     w_wr_state_nxt = W_IDLE;
         default: w_wr_state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      m_araddr = '0; m_arid = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
      m_arvalid = 1'b0; m_rready = 1'b0;
      m_awaddr = '0; m_awid = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
      m_awvalid = 1'b0;
      m_wdata = '0; m_wstrb = '0; m_wlast = 1'b0; m_wvalid = 1'b0; m_bready = 1'b0;
      s0_arready = 1'b0; s0_rid = '0; s0_rdata = '0; s0_rresp = '0; s0_rlast = 1'b0;
      s0_rvalid = 1'b0; s0_awready = 1'b0; s0_wready = 1'b0;
      s0_bid = '0; s0_bresp = '0; s0_bvalid = 1'b0;
      s1_arready = 1'b0; s1_rid = '0; s1_rdata = '0; s1_rresp = '0; s1_rlast = 1'b0;
      s1_rvalid = 1'b0; s1_awready = 1'b0; s1_wready = 1'b0;
      s1_bid = '0; s1_bresp = '0; s1_bvalid = 1'b0;

      if (r_rd_state == R_ADDR) begin
         m_araddr  = r_rg ? s1_araddr  : s0_araddr;
         m_arid    = r_rg ? s1_arid    : s0_arid;
         m_arlen   = r_rg ? s1_arlen   : s0_arlen;
         m_arsize  = r_rg ? s1_arsize  : s0_arsize;
         m_arburst = r_rg ? s1_arburst : s0_arburst;
         m_arvalid = w_sel_arvalid;
         if (r_rg) s1_arready = m_arready;
         else      s0_arready = m_arready;
      end

      if (r_rd_state == R_DATA) begin
         m_rready = w_sel_rready;
         if (r_rg) begin
            s1_rid = m_rid; s1_rdata = m_rdata; s1_rresp = m_rresp;
            s1_rlast = m_rlast; s1_rvalid = m_rvalid;
         end else begin
            s0_rid = m_rid; s0_rdata = m_rdata; s0_rresp = m_rresp;
            s0_rlast = m_rlast; s0_rvalid = m_rvalid;
         end
      end

      // AW and W run side by side; each channel is closed off once its handshake is done.
      if (r_wr_state == W_ACT) begin
         m_awaddr  = r_wg ? s1_awaddr  : s0_awaddr;
         m_awid    = r_wg ? s1_awid    : s0_awid;
         m_awlen   = r_wg ? s1_awlen   : s0_awlen;
         m_awsize  = r_wg ? s1_awsize  : s0_awsize;
         m_awburst = r_wg ? s1_awburst : s0_awburst;
         m_awvalid = w_sel_awvalid && !r_aw_done;
         m_wdata   = r_wg ? s1_wdata : s0_wdata;
         m_wstrb   = r_wg ? s1_wstrb : s0_wstrb;
         m_wlast   = w_sel_wlast;
         m_wvalid  = w_sel_wvalid && !r_w_done;
         if (r_wg) begin
            s1_awready = m_awready && !r_aw_done;
            s1_wready  = m_wready && !r_w_done;
         end else begin
            s0_awready = m_awready && !r_aw_done;
            s0_wready  = m_wready && !r_w_done;
         end
      end

      if (r_wr_state == W_RESP) begin
         m_bready = w_sel_bready;
         if (r_wg) begin
            s1_bid = m_bid; s1_bresp = m_bresp; s1_bvalid = m_bvalid;
         end else begin
            s0_bid = m_bid; s0_bresp = m_bresp; s0_bvalid = m_bvalid;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_arbiter_2x1.sv
`default_nettype none
//==============================================================================
// Module   : tb_axi_arbiter_2x1
// Brief    : Directed self-checking bench; the bench itself plays the SRAM slave.
// Revision : 1.0
//==============================================================================
module tb_axi_arbiter_2x1;
   import axi_arb_pkg::*;

   logic aclk = 1'b0;
   logic aresetn;
   always #5 aclk = ~aclk;

   logic [31:0] s0_araddr, s1_araddr, m_araddr, s0_awaddr, s1_awaddr, m_awaddr;
   logic [3:0]  s0_arid, s1_arid, m_arid, s0_rid, s1_rid, m_rid;
   logic [3:0]  s0_awid, s1_awid, m_awid, s0_bid, s1_bid, m_bid;
   logic [7:0]  s0_arlen, s1_arlen, m_arlen, s0_awlen, s1_awlen, m_awlen;
   logic [2:0]  s0_arsize, s1_arsize, m_arsize, s0_awsize, s1_awsize, m_awsize;
   logic [1:0]  s0_arburst, s1_arburst, m_arburst, s0_awburst, s1_awburst, m_awburst;
   logic        s0_arvalid, s1_arvalid, m_arvalid, s0_arready, s1_arready, m_arready;
   logic [63:0] s0_rdata, s1_rdata, m_rdata, s0_wdata, s1_wdata, m_wdata;
   logic [1:0]  s0_rresp, s1_rresp, m_rresp, s0_bresp, s1_bresp, m_bresp;
   logic        s0_rlast, s1_rlast, m_rlast, s0_rvalid, s1_rvalid, m_rvalid;
   logic        s0_rready, s1_rready, m_rready;
   logic        s0_awvalid, s1_awvalid, m_awvalid, s0_awready, s1_awready, m_awready;
   logic [7:0]  s0_wstrb, s1_wstrb, m_wstrb;
   logic        s0_wlast, s1_wlast, m_wlast, s0_wvalid, s1_wvalid, m_wvalid;
   logic        s0_wready, s1_wready, m_wready;
   logic        s0_bvalid, s1_bvalid, m_bvalid, s0_bready, s1_bready, m_bready;

   axi_arbiter_2x1 u_dut (
      .aclk, .aresetn,
      .s0_araddr, .s0_arid, .s0_arlen, .s0_arsize, .s0_arburst, .s0_arvalid, .s0_arready,
      .s0_rid, .s0_rdata, .s0_rresp, .s0_rlast, .s0_rvalid, .s0_rready,
      .s0_awaddr, .s0_awid, .s0_awlen, .s0_awsize, .s0_awburst, .s0_awvalid, .s0_awready,
      .s0_wdata, .s0_wstrb, .s0_wlast, .s0_wvalid, .s0_wready,
      .s0_bid, .s0_bresp, .s0_bvalid, .s0_bready,
      .s1_araddr, .s1_arid, .s1_arlen, .s1_arsize, .s1_arburst, .s1_arvalid, .s1_arready,
      .s1_rid, .s1_rdata, .s1_rresp, .s1_rlast, .s1_rvalid, .s1_rready,
      .s1_awaddr, .s1_awid, .s1_awlen, .s1_awsize, .s1_awburst, .s1_awvalid, .s1_awready,
      .s1_wdata, .s1_wstrb, .s1_wlast, .s1_wvalid, .s1_wready,
      .s1_bid, .s1_bresp, .s1_bvalid, .s1_bready,
      .m_araddr, .m_arid, .m_arlen, .m_arsize, .m_arburst, .m_arvalid, .m_arready,
      .m_rid, .m_rdata, .m_rresp, .m_rlast, .m_rvalid, .m_rready,
      .m_awaddr, .m_awid, .m_awlen, .m_awsize, .m_awburst, .m_awvalid, .m_awready,
      .m_wdata, .m_wstrb, .m_wlast, .m_wvalid, .m_wready,
      .m_bid, .m_bresp, .m_bvalid, .m_bready
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic idle_inputs();
      {s0_araddr, s0_arid, s0_arlen, s0_arsize, s0_arburst, s0_arvalid, s0_rready} = '0;
      {s1_araddr, s1_arid, s1_arlen, s1_arsize, s1_arburst, s1_arvalid, s1_rready} = '0;
      {s0_awaddr, s0_awid, s0_awlen, s0_awsize, s0_awburst, s0_awvalid} = '0;
      {s1_awaddr, s1_awid, s1_awlen, s1_awsize, s1_awburst, s1_awvalid} = '0;
      {s0_wdata, s0_wstrb, s0_wlast, s0_wvalid, s0_bready} = '0;
      {s1_wdata, s1_wstrb, s1_wlast, s1_wvalid, s1_bready} = '0;
      {m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid} = '0;
      {m_awready, m_wready, m_bid, m_bresp, m_bvalid} = '0;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      idle_inputs();
      step();
      aresetn = 1'b1;
   endtask

   task automatic req_read(input bit m, input logic [31:0] addr, input logic [7:0] len,
                           input logic [3:0] id);
      if (m) begin
         s1_araddr = addr; s1_arlen = len; s1_arid = id; s1_arsize = 3'd3;
         s1_arburst = BURST_INCR; s1_arvalid = 1'b1;
      end else begin
         s0_araddr = addr; s0_arlen = len; s0_arid = id; s0_arsize = 3'd3;
         s0_arburst = BURST_INCR; s0_arvalid = 1'b1;
      end
   endtask

   task automatic req_write(input bit m, input logic [31:0] addr, input logic [3:0] id,
                            input logic [63:0] data);
      if (m) begin
         s1_awaddr = addr; s1_awid = id; s1_awlen = 8'd0; s1_awsize = 3'd3;
         s1_awburst = BURST_INCR; s1_awvalid = 1'b1;
         s1_wdata = data; s1_wstrb = 8'hFF; s1_wlast = 1'b1; s1_wvalid = 1'b1;
      end else begin
         s0_awaddr = addr; s0_awid = id; s0_awlen = 8'd0; s0_awsize = 3'd3;
         s0_awburst = BURST_INCR; s0_awvalid = 1'b1;
         s0_wdata = data; s0_wstrb = 8'hFF; s0_wlast = 1'b1; s0_wvalid = 1'b1;
      end
   endtask

   // Entered mid-cycle with the DUT idle and master m's arvalid already up.
   task automatic read_burst(input bit m, input logic [31:0] addr, input logic [7:0] len,
                             input logic [3:0] id, input logic [1:0] resp);
      #1;
      chk("ar_bubble", m_arvalid, 0);
      step();
      chk("ar_valid", m_arvalid, 1);
      chk("ar_addr", m_araddr, addr);
      chk("ar_len", m_arlen, len);
      chk("ar_id", m_arid, id);
      chk("ar_burst", m_arburst, BURST_INCR);
      m_arready = 1'b1;
      #1;
      chk("arready_gnt", m ? s1_arready : s0_arready, 1);
      chk("arready_oth", m ? s0_arready : s1_arready, 0);
      step();
      m_arready = 1'b0;
      if (m) s1_arvalid = 1'b0; else s0_arvalid = 1'b0;
      s0_rready = 1'b1;
      s1_rready = 1'b1;
      for (int i = 0; i <= int'(len); i++) begin
         m_rvalid = 1'b1; m_rid = id; m_rdata = {addr, 32'(i)};
         m_rresp = resp; m_rlast = (i == int'(len));
         #1;
         chk("r_valid", m ? s1_rvalid : s0_rvalid, 1);
         chk("r_data", m ? s1_rdata : s0_rdata, {addr, 32'(i)});
         chk("r_last", m ? s1_rlast : s0_rlast, (i == int'(len)));
         chk("r_resp", m ? s1_rresp : s0_rresp, resp);
         chk("r_id", m ? s1_rid : s0_rid, id);
         chk("r_oth_valid", m ? s0_rvalid : s1_rvalid, 0);
         chk("r_oth_data", m ? s0_rdata : s1_rdata, 0);
         chk("r_rready", m_rready, 1);
         chk("r_no_aw", m_awvalid, 0);
         step();
      end
      m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
   endtask

   // Single-beat write; split delays the W handshake by one cycle after AW.
   task automatic write_one(input bit m, input logic [31:0] addr, input logic [3:0] id,
                            input logic [63:0] data, input bit split);
      #1;
      chk("aw_bubble", m_awvalid, 0);
      step();
      chk("aw_valid", m_awvalid, 1);
      chk("aw_addr", m_awaddr, addr);
      chk("aw_id", m_awid, id);
      chk("w_valid", m_wvalid, 1);
      chk("w_data", m_wdata, data);
      chk("w_strb", m_wstrb, 8'hFF);
      chk("w_last", m_wlast, 1);
      chk("w_no_ar", m_arvalid, 0);
      m_awready = 1'b1;
      m_wready  = !split;
      #1;
      chk("awready_gnt", m ? s1_awready : s0_awready, 1);
      chk("wready_gnt", m ? s1_wready : s0_wready, !split);
      chk("awready_oth", m ? s0_awready : s1_awready, 0);
      step();
      m_awready = 1'b0;
      if (m) s1_awvalid = 1'b0; else s0_awvalid = 1'b0;
      if (split) begin
         s0_bready = 1'b1; s1_bready = 1'b1;
         #1;
         chk("b_early_bready", m_bready, 0);
         chk("w_valid_held", m_wvalid, 1);
         m_wready = 1'b1;
         #1;
         chk("wready_late", m ? s1_wready : s0_wready, 1);
         step();
      end
      m_wready = 1'b0;
      if (m) begin s1_wvalid = 1'b0; s1_wlast = 1'b0; end
      else   begin s0_wvalid = 1'b0; s0_wlast = 1'b0; end
      s0_bready = 1'b1; s1_bready = 1'b1;
      m_bvalid = 1'b1; m_bid = id; m_bresp = 2'b00;
      #1;
      chk("resp_no_wvalid", m_wvalid, 0);
      chk("b_valid", m ? s1_bvalid : s0_bvalid, 1);
      chk("b_id", m ? s1_bid : s0_bid, id);
      chk("b_resp", m ? s1_bresp : s0_bresp, 0);
      chk("b_oth_valid", m ? s0_bvalid : s1_bvalid, 0);
      chk("b_bready", m_bready, 1);
      step();
      m_bvalid = 1'b0; m_bid = '0;
      #1;
      chk("b_idle_bready", m_bready, 0);
   endtask

   initial begin
      // Reset with live-looking inputs: every output must stay 0.
      idle_inputs();
      aresetn = 1'b0;
      s0_araddr = 32'h8000_0000; s0_arvalid = 1'b1; s1_awvalid = 1'b1;
      s1_wvalid = 1'b1; m_rvalid = 1'b1; m_bvalid = 1'b1; s0_rready = 1'b1; s1_bready = 1'b1;
      #12;
      chk("rst_m_arvalid", m_arvalid, 0);
      chk("rst_m_araddr", m_araddr, 0);
      chk("rst_s0_arready", s0_arready, 0);
      chk("rst_m_rready", m_rready, 0);
      chk("rst_s0_rvalid", s0_rvalid, 0);
      chk("rst_m_awvalid", m_awvalid, 0);
      chk("rst_m_wvalid", m_wvalid, 0);
      chk("rst_m_bready", m_bready, 0);
      chk("rst_s1_bvalid", s1_bvalid, 0);
      idle_inputs();
      step();
      aresetn = 1'b1;

      // s0 alone, len 3
      req_read(0, 32'h8000_0000, 8'd3, 4'h5);
      read_burst(0, 32'h8000_0000, 8'd3, 4'h5, 2'b00);

      // simultaneous reads after reset: s0, s1, then s0, s1 again
      do_reset();
      req_read(0, 32'h8000_0100, 8'd1, 4'h1);
      req_read(1, 32'h8000_0200, 8'd1, 4'h2);
      read_burst(0, 32'h8000_0100, 8'd1, 4'h1, 2'b00);
      read_burst(1, 32'h8000_0200, 8'd1, 4'h2, 2'b00);
      req_read(0, 32'h8000_0300, 8'd0, 4'h3);
      req_read(1, 32'h8000_0400, 8'd0, 4'h4);
      read_burst(0, 32'h8000_0300, 8'd0, 4'h3, 2'b00);
      read_burst(1, 32'h8000_0400, 8'd0, 4'h4, 2'b00);

      // single-beat writes: AW+W together on s1, then split AW/W on s0
      req_write(1, 32'h8000_1000, 4'h3, 64'h1122_3344_5566_7788);
      write_one(1, 32'h8000_1000, 4'h3, 64'h1122_3344_5566_7788, 1'b0);
      req_write(0, 32'h8000_2000, 4'h6, 64'hCAFE_F00D_DEAD_BEEF);
      write_one(0, 32'h8000_2000, 4'h6, 64'hCAFE_F00D_DEAD_BEEF, 1'b1);

      // read/write collision after reset: read first, then the waiting write
      do_reset();
      req_read(0, 32'h8000_3000, 8'd1, 4'h7);
      req_write(1, 32'h8000_4000, 4'h8, 64'h0102_0304_0506_0708);
      read_burst(0, 32'h8000_3000, 8'd1, 4'h7, 2'b00);
      write_one(1, 32'h8000_4000, 4'h8, 64'h0102_0304_0506_0708, 1'b0);
      // last grant was a write, so the next collision goes to the read
      req_read(1, 32'h8000_3100, 8'd0, 4'h9);
      req_write(0, 32'h8000_4100, 4'hA, 64'h1111_2222_3333_4444);
      read_burst(1, 32'h8000_3100, 8'd0, 4'h9, 2'b00);
      write_one(0, 32'h8000_4100, 4'hA, 64'h1111_2222_3333_4444, 1'b0);
      // after a lone read the next collision goes to the write
      req_read(0, 32'h8000_3200, 8'd0, 4'hB);
      read_burst(0, 32'h8000_3200, 8'd0, 4'hB, 2'b00);
      req_read(1, 32'h8000_3300, 8'd0, 4'hC);
      req_write(1, 32'h8000_4200, 4'hD, 64'h5555_6666_7777_8888);
      write_one(1, 32'h8000_4200, 4'hD, 64'h5555_6666_7777_8888, 1'b0);
      read_burst(1, 32'h8000_3300, 8'd0, 4'hC, 2'b00);

      // reset in the middle of an 8-beat s0 read, at beat index 3
      do_reset();
      req_read(0, 32'h8000_5000, 8'd7, 4'h1);
      step();
      m_arready = 1'b1;
      step();
      m_arready = 1'b0; s0_arvalid = 1'b0; s0_rready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         m_rvalid = 1'b1; m_rid = 4'h1; m_rdata = 64'(i);
         step();
      end
      m_rvalid = 1'b1; m_rdata = 64'h3;
      #1;
      chk("mid_rvalid_pre", s0_rvalid, 1);
      aresetn = 1'b0;
      #1;
      chk("mid_rst_rvalid", s0_rvalid, 0);
      chk("mid_rst_rdata", s0_rdata, 0);
      chk("mid_rst_rready", m_rready, 0);
      chk("mid_rst_arvalid", m_arvalid, 0);
      idle_inputs();
      step();
      aresetn = 1'b1;
      req_read(1, 32'h8000_6000, 8'd0, 4'h2);
      read_burst(1, 32'h8000_6000, 8'd0, 4'h2, 2'b00);

      // SLVERR on a single-beat s1 read passes through unchanged
      req_read(1, 32'h8000_7000, 8'd0, 4'hE);
      read_burst(1, 32'h8000_7000, 8'd0, 4'hE, 2'b10);
      m_rvalid = 1'b1; m_bvalid = 1'b1; s1_rready = 1'b1; s0_bready = 1'b1;
      #1;
      chk("idle_rready", m_rready, 0);
      chk("idle_s1_rvalid", s1_rvalid, 0);
      chk("idle_bready", m_bready, 0);
      idle_inputs();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
